// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and the control unit.
// Provides the instruction width, the opcode field position and the opcode encodings.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 4;

  typedef enum logic [OPC_W-1:0] {
    OpAdd    = 4'h0,
    OpSub    = 4'h1,
    OpAnd    = 4'h2,
    OpOr     = 4'h3,
    OpLoad   = 4'h4,
    OpStore  = 4'h5,
    OpBranch = 4'h6,
    OpHalt   = 4'hF
  } opcode_e;

  // Opcode lives in the top OPC_W bits of the instruction word.
  function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO holding fetched {instruction, pc} records.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   push_i, wdata_i  write a record (caller guarantees no overflow)
//   pop_i            drop the head record (ignored when empty)
//   flush_i          empty the FIFO; stored data is kept so the head holds its value
//   head_o           head record, straight from a register
//   count_o          current occupancy; count_next_o is next cycle's occupancy
module fetch_fifo #(
  parameter int unsigned Width = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] head_o,
  output logic [1:0]       count_o,
  output logic [1:0]       count_next_o
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic [1:0]       count_q, count_d;
  logic             pop_ok;
  logic             wr_slot0;

  assign pop_ok   = pop_i && (count_q != 2'd0);
  // Slot 0 is always the head; a push lands just behind whatever survives the pop.
  assign wr_slot0 = (count_q == 2'd0) || ((count_q == 2'd1) && pop_ok);

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    count_d  = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      // Popping the last entry leaves slot 0 untouched so the head fields hold.
      if (pop_ok && (count_q == 2'd2)) mem_d[0] = mem_q[1];
      if (push_i) begin
        if (wr_slot0) mem_d[0] = wdata_i;
        else          mem_d[1] = wdata_i;
      end
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      count_q  <= count_d;
    end
  end

  assign head_o       = mem_q[0];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to a variable-latency
// instruction memory, buffers responses in a 2-entry FIFO and hands them to decode.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req/addr/gnt              request channel (issued on req & gnt)
//   imem_rvalid/rdata              in-order response channel
//   br_taken, br_target            redirect: flush, drop in-flight data, restart at target
//   id_valid/ready/instr/opcode/pc head-of-buffer handshake towards decode/control
//   halted                         fetch stopped after a HALT_OP instruction was buffered
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OP  = OpHalt
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [3:0]         id_opcode,
  output logic [PC_W-1:0]    id_pc,
  output logic               halted
);

  localparam int unsigned EntW = INSTR_W + PC_W;

  localparam logic [0:0] StRun    = 1'b0;
  localparam logic [0:0] StHalted = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [1:0]      out_q, out_d;     // requests issued but not yet answered
  logic [1:0]      drop_q, drop_d;   // in-flight responses still to be thrown away
  logic [PC_W-1:0] aq_q [2];         // addresses of in-flight requests, head at [0]
  logic [PC_W-1:0] aq_d [2];
  logic            issue, push, pop;
  logic [1:0]      fifo_cnt, fifo_cnt_next;
  logic [EntW-1:0] head;

  // The registered request is masked during a redirect so it can never be granted
  // in the same cycle the PC is being replaced.
  assign imem_req  = req_q & ~br_taken;
  assign imem_addr = pc_q;
  assign issue     = imem_req & imem_gnt;
  assign push      = imem_rvalid & (drop_q == 2'd0) & ~br_taken;
  assign pop       = id_valid & id_ready;

  fetch_fifo #(
    .Width(EntW)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (br_taken),
    .wdata_i     ({imem_rdata, aq_q[0]}),
    .head_o      (head),
    .count_o     (fifo_cnt),
    .count_next_o(fifo_cnt_next)
  );

  assign id_valid  = (fifo_cnt != 2'd0);
  assign id_instr  = head[EntW-1 -: INSTR_W];
  assign id_opcode = head[EntW-1 -: OPC_W];
  assign id_pc     = head[PC_W-1:0];
  assign halted    = (state_q == StHalted);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    aq_d[0] = aq_q[0];
    aq_d[1] = aq_q[1];
    drop_d  = drop_q;
    out_d   = out_q + {1'b0, issue} - {1'b0, imem_rvalid};

    if (imem_rvalid) begin
      aq_d[0] = aq_q[1];
      if (drop_q != 2'd0) drop_d = drop_q - 2'd1;
    end

    if (issue) begin
      pc_d = pc_q + PC_W'(1);
      if ((out_q == 2'd0) || ((out_q == 2'd1) && imem_rvalid)) aq_d[0] = pc_q;
      else                                                      aq_d[1] = pc_q;
    end

    if (push && (imem_rdata[INSTR_W-1 -: OPC_W] == HALT_OP)) state_d = StHalted;

    // Every response still outstanding after this cycle belongs to the old path.
    if (br_taken) begin
      pc_d    = br_target;
      state_d = StRun;
      drop_d  = out_d;
    end

    // Credit uses next-cycle occupancy so the registered request is always legal.
    req_d = (state_d == StRun) && !br_taken &&
            (({1'b0, fifo_cnt_next} + {1'b0, out_d}) < 3'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      out_q   <= 2'd0;
      drop_q  <= 2'd0;
      aq_q[0] <= '0;
      aq_q[1] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      aq_q[0] <= aq_d[0];
      aq_q[1] <= aq_d[1];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level reference model (queues of in-flight
// requests and buffered instructions), directed table cases, hand-written corner
// sequences and a randomized phase.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        br_taken = 1'b0;
  logic [7:0]  br_target = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [15:0] id_instr;
  logic [3:0]  id_opcode;
  logic [7:0]  id_pc;
  logic        halted;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_W    (8),
    .INSTR_W (16),
    .RESET_PC(8'h00),
    .HALT_OP (4'hF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_opcode  (id_opcode),
    .id_pc      (id_pc),
    .halted     (halted)
  );

  typedef struct { logic [7:0] addr; int ready_at; bit drop; } rsp_t;
  typedef struct { logic [15:0] instr; logic [7:0] pc; } ent_t;
  typedef struct {
    string name; bit use_br; logic [7:0] start; int gnt_pct; int lat_max;
    logic [7:0] e0; logic [7:0] e1; logic [7:0] e2;
  } vec_t;

  logic [15:0] mem [256];
  rsp_t        mq[$];    // requests accepted by memory, in issue order
  ent_t        fq[$];    // instructions the fetch buffer should hold
  ent_t        dlv[$];   // instructions handed to decode since the last redirect
  logic [7:0]  m_pc;
  bit          m_halted;
  int          cyc, n_issue, checks, errors;
  int          gnt_pct = 100, ready_pct = 100, lat_min = 1, lat_max = 1, br_pct = 0;
  bit          br_req, br_on_rsp, saw_coinc, prev_req, prev_gnt;
  logic [7:0]  br_tgt, br_rsp_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    rsp_t r;
    ent_t e;
    bit   rv;
    @(negedge clk);
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    id_ready    = ($urandom_range(99) < ready_pct);
    rv          = (mq.size() != 0) && (mq[0].ready_at <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem[mq[0].addr] : 16'($urandom);
    br_taken    = 1'b0;
    if (br_req) begin
      br_taken = 1'b1; br_target = br_tgt; br_req = 1'b0;
    end else if (br_on_rsp && rv && (mq[0].addr == br_rsp_addr)) begin
      br_taken = 1'b1; br_target = br_tgt; br_on_rsp = 1'b0; saw_coinc = 1'b1;
    end else if ((br_pct != 0) && ($urandom_range(99) < br_pct)) begin
      br_taken = 1'b1; br_target = 8'($urandom);
    end
    #1;
    chk("halted", 32'(halted), 32'(m_halted));
    chk("id_valid", 32'(id_valid), 32'(fq.size() != 0));
    if (id_valid && (fq.size() != 0)) begin
      chk("id_pc", 32'(id_pc), 32'(fq[0].pc));
      chk("id_instr", 32'(id_instr), 32'(fq[0].instr));
      chk("id_opcode", 32'(id_opcode), 32'(fq[0].instr[15:12]));
    end
    if (br_taken) chk("req_during_br", 32'(imem_req), 0);
    if (imem_req) begin
      chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("credit", 32'((fq.size() + mq.size()) < 2), 1);
      chk("req_while_halted", 32'(m_halted), 0);
    end
    if (prev_req && !prev_gnt && !br_taken && !m_halted) chk("req_hold", 32'(imem_req), 1);
    // Model update for the coming clock edge.
    if (id_valid && id_ready && (fq.size() != 0)) begin
      e = fq.pop_front();
      dlv.push_back(e);
    end
    if (rv) begin
      r = mq.pop_front();
      if (!r.drop && !br_taken) begin
        e.instr = mem[r.addr];
        e.pc    = r.addr;
        fq.push_back(e);
        if (e.instr[15:12] == 4'hF) m_halted = 1'b1;
      end
    end
    if (imem_req && imem_gnt) begin
      r.addr     = m_pc;
      r.ready_at = cyc + int'($urandom_range(lat_max, lat_min));
      r.drop     = 1'b0;
      mq.push_back(r);
      m_pc = m_pc + 8'd1;
      n_issue++;
    end
    if (br_taken) begin
      foreach (mq[i]) mq[i].drop = 1'b1;
      fq.delete();
      dlv.delete();
      m_pc     = br_target;
      m_halted = 1'b0;
    end
    prev_req = imem_req;
    prev_gnt = imem_gnt;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; br_taken = 1'b0; id_ready = 1'b0;
    br_req = 1'b0; br_on_rsp = 1'b0; br_pct = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete(); fq.delete(); dlv.delete();
    m_pc = 8'h00; m_halted = 1'b0; n_issue = 0; prev_req = 1'b0; prev_gnt = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_id_valid", 32'(id_valid), 0);
    chk("rst_id_instr", 32'(id_instr), 0);
    chk("rst_id_opcode", 32'(id_opcode), 0);
    chk("rst_id_pc", 32'(id_pc), 0);
    chk("rst_halted", 32'(halted), 0);
    cyc++;
  endtask

  task automatic run_until_dlv(input string name, input int n, input int budget);
    int k = 0;
    while ((dlv.size() < n) && (k < budget)) begin
      step();
      k++;
    end
    chk({name, "_delivered"}, 32'(dlv.size() >= n), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int   n0;
    bit   found;

    vecs[0] = '{"reset_seq",   1'b0, 8'h00, 100, 1, 8'h00, 8'h01, 8'h02};
    vecs[1] = '{"redirect_40", 1'b1, 8'h40, 100, 1, 8'h40, 8'h41, 8'h42};
    vecs[2] = '{"wrap_ff",     1'b1, 8'hFE,  50, 3, 8'hFE, 8'hFF, 8'h00};
    vecs[3] = '{"slow_mem",    1'b1, 8'h80,  30, 5, 8'h80, 8'h81, 8'h82};

    for (int i = 0; i < 256; i++) mem[i] = {8'h00, 8'(i)};

    // Directed table cases.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      gnt_pct = vecs[v].gnt_pct; ready_pct = 100; lat_min = 1; lat_max = vecs[v].lat_max;
      if (vecs[v].use_br) begin
        br_req = 1'b1;
        br_tgt = vecs[v].start;
      end
      run_until_dlv(vecs[v].name, 3, 300);
      if (dlv.size() >= 3) begin
        chk({vecs[v].name, "_pc0"}, 32'(dlv[0].pc), 32'(vecs[v].e0));
        chk({vecs[v].name, "_pc1"}, 32'(dlv[1].pc), 32'(vecs[v].e1));
        chk({vecs[v].name, "_pc2"}, 32'(dlv[2].pc), 32'(vecs[v].e2));
        chk({vecs[v].name, "_data0"}, 32'(dlv[0].instr), 32'(mem[vecs[v].start]));
      end
    end

    // Decode stalled: exactly two requests fill the buffer, then in-order drain.
    do_reset();
    gnt_pct = 100; ready_pct = 0; lat_min = 1; lat_max = 1;
    repeat (10) step();
    chk("stall_issues", 32'(n_issue), 2);
    chk("stall_req_low", 32'(imem_req), 0);
    chk("stall_valid", 32'(id_valid), 1);
    chk("stall_head_pc", 32'(id_pc), 0);
    ready_pct = 100;
    run_until_dlv("stall_release", 3, 50);
    if (dlv.size() >= 3) begin
      chk("stall_pc0", 32'(dlv[0].pc), 0);
      chk("stall_pc1", 32'(dlv[1].pc), 1);
      chk("stall_pc2", 32'(dlv[2].pc), 2);
    end

    // Redirect with one slow response in flight.
    do_reset();
    gnt_pct = 100; ready_pct = 100; lat_min = 8; lat_max = 8;
    for (int k = 0; (k < 20) && (n_issue == 0); k++) step();
    gnt_pct = 0;
    chk("one_outstanding", 32'(mq.size()), 1);
    br_req = 1'b1; br_tgt = 8'h40;
    step();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    run_until_dlv("late_drop", 1, 40);
    if (dlv.size() >= 1) begin
      chk("late_drop_pc", 32'(dlv[0].pc), 32'h40);
      chk("late_drop_data", 32'(dlv[0].instr), 32'(mem[8'h40]));
    end

    // Redirect in the same cycle as the response for pc 5.
    do_reset();
    gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
    br_on_rsp = 1'b1; br_rsp_addr = 8'h05; br_tgt = 8'h20; saw_coinc = 1'b0;
    for (int k = 0; (k < 60) && !saw_coinc; k++) step();
    chk("coinc_seen", 32'(saw_coinc), 1);
    run_until_dlv("coinc", 2, 40);
    found = 1'b0;
    foreach (dlv[i]) if (dlv[i].pc == 8'h05) found = 1'b1;
    chk("coinc_no_pc5", 32'(found), 0);
    if (dlv.size() >= 1) chk("coinc_first_pc", 32'(dlv[0].pc), 32'h20);

    // HALT at address 3, then resume via redirect.
    mem[3] = {4'hF, 12'h003};
    do_reset();
    gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
    for (int k = 0; (k < 40) && !halted; k++) step();
    chk("halt_set", 32'(halted), 1);
    n0 = n_issue;
    repeat (15) step();
    chk("halt_no_issue", 32'(n_issue), 32'(n0));
    found = 1'b0;
    foreach (dlv[i]) if ((dlv[i].pc == 8'h03) && (dlv[i].instr[15:12] == 4'hF)) found = 1'b1;
    chk("halt_delivered", 32'(found), 1);
    br_req = 1'b1; br_tgt = 8'h10;
    step();
    run_until_dlv("resume", 1, 40);
    chk("resume_halted", 32'(halted), 0);
    if (dlv.size() >= 1) chk("resume_pc", 32'(dlv[0].pc), 32'h10);
    mem[3] = {8'h00, 8'h03};

    // Randomized traffic against the model.
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    do_reset();
    for (int blk = 0; blk < 30; blk++) begin
      gnt_pct   = int'($urandom_range(100, 20));
      ready_pct = int'($urandom_range(100, 10));
      lat_min   = 1;
      lat_max   = int'($urandom_range(4, 1));
      br_pct    = 3;
      repeat (100) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
